// File: rtl/dfd_pkg.sv
// Shared definitions for the DFD APB CSR fabric: region codes, FSM states and target numbering.
// Target order is MCR, TR, then all CLA, all NTR and all DST instances.
package dfd_pkg;

   localparam int MAX_NUM_TRACE_INST = 8;
   localparam int DFD_APB_DATA_WIDTH = 32;
   localparam int DFD_APB_ADDR_WIDTH = 23;
   localparam int TGT_IDX_W          = 5;

   localparam logic [3:0] REG_MCR = 4'd0;
   localparam logic [3:0] REG_TR  = 4'd1;
   localparam logic [3:0] REG_CLA = 4'd2;
   localparam logic [3:0] REG_NTR = 4'd3;
   localparam logic [3:0] REG_DST = 4'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } fab_state_t;

   // MCR and TR are singletons, so the instance field is ignored for them.
   function automatic logic [TGT_IDX_W-1:0] tgt_index(input logic [3:0] region,
                                                       input logic [2:0] inst,
                                                       input int         num_inst);
      int idx;
      case (region)
         REG_MCR: idx = 0;
         REG_TR:  idx = 1;
         REG_CLA: idx = 2 + int'(inst);
         REG_NTR: idx = 2 + num_inst + int'(inst);
         REG_DST: idx = 2 + 2 * num_inst + int'(inst);
         default: idx = 0;
      endcase
      return TGT_IDX_W'(idx);
   endfunction

endpackage

// File: rtl/dfd_apb_addr_decode.sv
// Combinational APB address decode: target index, register offset and decode error.
// Zero latency; no flow control of its own.
module dfd_apb_addr_decode
   import dfd_pkg::*;
#(
   parameter int NUM_INST = MAX_NUM_TRACE_INST,
   parameter int ADDR_W   = DFD_APB_ADDR_WIDTH
) (
   input  logic [ADDR_W-1:0]    paddr,
   output logic [TGT_IDX_W-1:0] sel,
   output logic [11:0]          offset,
   output logic                 dec_err
);

   logic [2:0] inst;
   logic [3:0] region;
   logic       inst_bad;
   logic       hi_bad;

   assign inst     = paddr[18:16];
   assign region   = paddr[15:12];
   assign offset   = paddr[11:0];
   assign hi_bad   = |(paddr >> 19);
   assign inst_bad = (region >= REG_CLA) && (int'(inst) >= NUM_INST);
   assign dec_err  = (region > REG_DST) | inst_bad | (paddr[1:0] != 2'b00) | hi_bad;
   assign sel      = tgt_index(region, inst, NUM_INST);

endmodule

// File: rtl/dfd_apb_csr_fabric.sv
// APB slave fanning out to one-hot CSR targets; one access in flight, response one cycle after ack.
// Unacked accesses time out after TIMEOUT wait cycles with pslverr; psel dropping mid-wait aborts silently.
module dfd_apb_csr_fabric
   import dfd_pkg::*;
#(
   parameter int  NUM_INST = MAX_NUM_TRACE_INST,
   parameter int  DATA_W   = DFD_APB_DATA_WIDTH,
   parameter int  ADDR_W   = DFD_APB_ADDR_WIDTH,
   parameter int  TIMEOUT  = 64,
   localparam int NUM_TGT  = 2 + 3 * NUM_INST
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [ADDR_W-1:0]         paddr,
   input  logic [DATA_W-1:0]         pwdata,
   input  logic [DATA_W/8-1:0]       pstrb,
   output logic                      pready,
   output logic                      pslverr,
   output logic [DATA_W-1:0]         prdata,
   output logic [NUM_TGT-1:0]        tgt_req,
   output logic                      tgt_we,
   output logic [11:0]               tgt_addr,
   output logic [DATA_W-1:0]         tgt_wdata,
   output logic [DATA_W/8-1:0]       tgt_wstrb,
   input  logic [NUM_TGT-1:0]        tgt_ack,
   input  logic [NUM_TGT-1:0]        tgt_err,
   input  logic [NUM_TGT*DATA_W-1:0] tgt_rdata,
   output logic [15:0]               timeout_cnt
);

   fab_state_t           state;
   fab_state_t           state_nxt;
   logic [TGT_IDX_W-1:0] dec_sel;
   logic [11:0]          dec_offset;
   logic                 dec_err;
   logic [15:0]          wait_cnt;
   logic [NUM_TGT-1:0]   req_q;
   logic                 err_q;
   logic [DATA_W-1:0]    rdata_q;
   logic                 start;
   logic                 ack_hit;
   logic                 to_hit;
   logic                 abort;
   logic                 ack_sel;
   logic                 err_sel;
   logic [DATA_W-1:0]    rdata_sel;

   dfd_apb_addr_decode #(
      .NUM_INST (NUM_INST),
      .ADDR_W   (ADDR_W)
   ) u_decode (
      .paddr   (paddr),
      .sel     (dec_sel),
      .offset  (dec_offset),
      .dec_err (dec_err)
   );

   // req_q is one-hot on the selected target, so masking with it ignores every other target.
   assign ack_sel = |(tgt_ack & req_q);
   assign err_sel = |(tgt_err & req_q);

   always_comb begin
      rdata_sel = '0;
      for (int i = 0; i < NUM_TGT; i++) begin
         if (req_q[i]) begin
            rdata_sel = rdata_sel | tgt_rdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      ack_hit   = 1'b0;
      to_hit    = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (psel && !penable) begin
               start     = 1'b1;
               state_nxt = dec_err ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (!psel) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end else if (ack_sel) begin
               ack_hit   = 1'b1;
               state_nxt = RESP;
            end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
               to_hit    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_q       <= '0;
         tgt_we      <= 1'b0;
         tgt_addr    <= '0;
         tgt_wdata   <= '0;
         tgt_wstrb   <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         wait_cnt    <= '0;
         timeout_cnt <= '0;
      end else begin
         if (start) begin
            tgt_we    <= pwrite;
            tgt_addr  <= dec_offset;
            tgt_wdata <= pwdata;
            tgt_wstrb <= pstrb;
            err_q     <= dec_err;
            rdata_q   <= '0;
            wait_cnt  <= '0;
            req_q     <= dec_err ? '0 : (NUM_TGT'(1) << dec_sel);
         end
         if (state == WAIT) begin
            wait_cnt <= wait_cnt + 16'd1;
            if (ack_hit) begin
               req_q   <= '0;
               err_q   <= err_sel;
               rdata_q <= tgt_we ? '0 : rdata_sel;
            end
            if (to_hit) begin
               req_q   <= '0;
               err_q   <= 1'b1;
               rdata_q <= '0;
               if (timeout_cnt != 16'hFFFF) begin
                  timeout_cnt <= timeout_cnt + 16'd1;
               end
            end
            if (abort) begin
               req_q <= '0;
            end
         end
      end
   end

   assign tgt_req = req_q;
   assign pready  = (state == RESP);
   assign pslverr = (state == RESP) && err_q;
   assign prdata  = ((state == RESP) && !err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_dfd_apb_csr_fabric.sv
// Bench for dfd_apb_csr_fabric: a wide instance (8 trace instances) and a narrow one (2 instances, short timeout).
// Directed table, hand-written corner sequences and random accesses checked against an address-map model.
module tb_dfd_apb_csr_fabric;

   localparam int NA  = 8;
   localparam int NB  = 2;
   localparam int TA  = 8;
   localparam int TB  = 4;
   localparam int NTA = 2 + 3 * NA;
   localparam int NTB = 2 + 3 * NB;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        psel_a, psel_b, penable, pwrite;
   logic [22:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;

   logic              pready_a, pslverr_a, tgt_we_a;
   logic [31:0]       prdata_a, tgt_wdata_a;
   logic [NTA-1:0]    tgt_req_a, tgt_ack_a, tgt_err_a;
   logic [11:0]       tgt_addr_a;
   logic [3:0]        tgt_wstrb_a;
   logic [NTA*32-1:0] tgt_rdata_a;
   logic [15:0]       timeout_cnt_a;

   logic              pready_b, pslverr_b, tgt_we_b;
   logic [31:0]       prdata_b, tgt_wdata_b;
   logic [NTB-1:0]    tgt_req_b, tgt_ack_b, tgt_err_b;
   logic [11:0]       tgt_addr_b;
   logic [3:0]        tgt_wstrb_b;
   logic [NTB*32-1:0] tgt_rdata_b;
   logic [15:0]       timeout_cnt_b;

   dfd_apb_csr_fabric #(.NUM_INST(NA), .DATA_W(32), .ADDR_W(23), .TIMEOUT(TA)) dut_a (
      .clk(clk), .reset(reset), .psel(psel_a), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_a), .pslverr(pslverr_a),
      .prdata(prdata_a), .tgt_req(tgt_req_a), .tgt_we(tgt_we_a), .tgt_addr(tgt_addr_a),
      .tgt_wdata(tgt_wdata_a), .tgt_wstrb(tgt_wstrb_a), .tgt_ack(tgt_ack_a), .tgt_err(tgt_err_a),
      .tgt_rdata(tgt_rdata_a), .timeout_cnt(timeout_cnt_a));

   dfd_apb_csr_fabric #(.NUM_INST(NB), .DATA_W(32), .ADDR_W(23), .TIMEOUT(TB)) dut_b (
      .clk(clk), .reset(reset), .psel(psel_b), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_b), .pslverr(pslverr_b),
      .prdata(prdata_b), .tgt_req(tgt_req_b), .tgt_we(tgt_we_b), .tgt_addr(tgt_addr_b),
      .tgt_wdata(tgt_wdata_b), .tgt_wstrb(tgt_wstrb_b), .tgt_ack(tgt_ack_b), .tgt_err(tgt_err_b),
      .tgt_rdata(tgt_rdata_b), .timeout_cnt(timeout_cnt_b));

   typedef struct {
      bit          b;        // 1: narrow instance
      logic [22:0] addr;
      bit          wr;
      logic [31:0] wd;
      logic [3:0]  st;
      int          ack_cyc;  // request cycle carrying the ack, 0 = never
      logic [31:0] rd;
      bit          aerr;
      bit          e_err;
      int          e_idx;
      int          e_req;    // expected number of request cycles
      bit          e_to;     // expected to time out
      logic [31:0] e_rdata;
   } vec_t;

   int n_chk = 0;
   int n_err = 0;
   int cnt_a = 0;
   int cnt_b = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Address map model: region-major target numbering.
   function automatic void model_decode(input logic [22:0] a, input int n, output bit err, output int idx);
      int region, inst;
      region = int'((a >> 12) % 16);
      inst   = int'((a >> 16) % 8);
      err    = (region > 4) || (a % 4 != 0) || (a >= 23'h080000) ||
               (region >= 2 && region <= 4 && inst >= n);
      idx    = (region == 0) ? 0 : (region == 1) ? 1 : 2 + (region - 2) * n + inst;
   endfunction

   function automatic vec_t fill_expect(input vec_t v);
      bit de;
      int idx, t;
      model_decode(v.addr, v.b ? NB : NA, de, idx);
      t       = v.b ? TB : TA;
      v.e_idx = idx;
      v.e_to  = 0;
      if (de) begin
         v.e_err = 1; v.e_req = 0;
      end else if (v.ack_cyc == 0 || v.ack_cyc > t) begin
         v.e_err = 1; v.e_req = t; v.e_to = 1;
      end else begin
         v.e_err = v.aerr; v.e_req = v.ack_cyc;
      end
      v.e_rdata = (!v.e_err && !v.wr) ? v.rd : 32'h0;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      bit          seen, bad_req, bad_hold, got_err;
      int          req_cnt, lat;
      logic        rdy, serr, one_more;
      logic [31:0] rdat, req, got_rdata;
      logic [48:0] hold;
      @(posedge clk); #1;
      paddr = v.addr; pwrite = v.wr; pwdata = v.wd; pstrb = v.st; penable = 1'b0;
      if (v.b) psel_b = 1'b1; else psel_a = 1'b1;
      tgt_ack_a = '0; tgt_ack_b = '0; tgt_err_a = '1; tgt_err_b = '1;
      for (int i = 0; i < NTA; i++) tgt_rdata_a[i*32 +: 32] = 32'hA5A50000 | i;
      for (int i = 0; i < NTB; i++) tgt_rdata_b[i*32 +: 32] = 32'h5A5A0000 | i;
      seen = 0; bad_req = 0; bad_hold = 0; got_err = 0; req_cnt = 0; lat = 0; got_rdata = '0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(posedge clk); #1;
         penable = 1'b1;
         tgt_ack_a = '0; tgt_ack_b = '0;
         rdy  = v.b ? pready_b : pready_a;
         serr = v.b ? pslverr_b : pslverr_a;
         rdat = v.b ? prdata_b : prdata_a;
         req  = v.b ? 32'(tgt_req_b) : 32'(tgt_req_a);
         hold = v.b ? {tgt_we_b, tgt_addr_b, tgt_wdata_b, tgt_wstrb_b}
                    : {tgt_we_a, tgt_addr_a, tgt_wdata_a, tgt_wstrb_a};
         if (rdy) begin
            seen = 1; lat = c; got_err = serr; got_rdata = rdat;
            if (req != 0) bad_req = 1;
         end else if (req != 0) begin
            req_cnt++;
            if (req != (32'd1 << v.e_idx)) bad_req = 1;
            if (hold != {v.wr, v.addr[11:0], v.wd, v.st}) bad_hold = 1;
            if (req_cnt == v.ack_cyc) begin
               if (v.b) begin
                  tgt_ack_b = NTB'(1) << v.e_idx;
                  tgt_err_b = v.aerr ? '1 : ~(NTB'(1) << v.e_idx);
                  tgt_rdata_b[v.e_idx*32 +: 32] = v.rd;
               end else begin
                  tgt_ack_a = NTA'(1) << v.e_idx;
                  tgt_err_a = v.aerr ? '1 : ~(NTA'(1) << v.e_idx);
                  tgt_rdata_a[v.e_idx*32 +: 32] = v.rd;
               end
            end else begin
               // Acks from every other target must be ignored.
               if (v.b) tgt_ack_b = ~(NTB'(1) << v.e_idx);
               else     tgt_ack_a = ~(NTA'(1) << v.e_idx);
            end
         end
      end
      @(posedge clk); #1;
      one_more = v.b ? pready_b : pready_a;
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
      tgt_ack_a = '0; tgt_ack_b = '0;
      chk({tag, " pready_seen"}, seen, 1);
      chk({tag, " latency"}, lat, v.e_req + 1);
      chk({tag, " pslverr"}, got_err, v.e_err);
      chk({tag, " prdata"}, got_rdata, v.e_rdata);
      chk({tag, " req_cycles"}, req_cnt, v.e_req);
      chk({tag, " req_onehot"}, bad_req, 0);
      chk({tag, " req_fields_held"}, bad_hold, 0);
      chk({tag, " pready_one_cycle"}, one_more, 0);
      if (v.e_to) begin
         if (v.b) cnt_b++; else cnt_a++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test expected completion");
      $fatal(1);
   end

   initial begin
      vec_t tbl[15];
      vec_t v;
      int   t;

      tbl[0]  = '{0, 23'h052010, 0, 32'h0, 4'h0, 1, 32'hDEADBEEF, 0, 0, 7, 1, 0, 32'hDEADBEEF};
      tbl[1]  = '{0, 23'h001004, 1, 32'h12345678, 4'h3, 5, 32'hCAFEF00D, 0, 0, 1, 5, 0, 32'h0};
      tbl[2]  = '{0, 23'h000002, 0, 32'h0, 4'h0, 1, 32'h11111111, 0, 1, 0, 0, 0, 32'h0};
      tbl[3]  = '{0, 23'h005000, 0, 32'h0, 4'h0, 1, 32'h22222222, 0, 1, 0, 0, 0, 32'h0};
      tbl[4]  = '{0, 23'h080000, 1, 32'h5, 4'hF, 1, 32'h33333333, 0, 1, 0, 0, 0, 32'h0};
      tbl[5]  = '{0, 23'h070FFC, 0, 32'h0, 4'h0, 2, 32'h0BADCAFE, 0, 0, 0, 2, 0, 32'h0BADCAFE};
      tbl[6]  = '{0, 23'h074008, 1, 32'hA1B2C3D4, 4'hF, 3, 32'h0, 0, 0, 25, 3, 0, 32'h0};
      tbl[7]  = '{0, 23'h003000, 0, 32'h0, 4'h0, 0, 32'h77777777, 0, 1, 10, 8, 1, 32'h0};
      tbl[8]  = '{0, 23'h012ABC, 0, 32'h0, 4'h0, 8, 32'h13579BDF, 0, 0, 3, 8, 0, 32'h13579BDF};
      tbl[9]  = '{0, 23'h002000, 0, 32'h0, 4'h0, 2, 32'h99999999, 1, 1, 2, 2, 0, 32'h0};
      tbl[10] = '{1, 23'h034000, 0, 32'h0, 4'h0, 1, 32'h44444444, 0, 1, 0, 0, 0, 32'h0};
      tbl[11] = '{1, 23'h000002, 0, 32'h0, 4'h0, 1, 32'h55555555, 0, 1, 0, 0, 0, 32'h0};
      tbl[12] = '{1, 23'h001000, 0, 32'h0, 4'h0, 0, 32'h66666666, 0, 1, 1, 4, 1, 32'h0};
      tbl[13] = '{1, 23'h014010, 0, 32'h0, 4'h0, 4, 32'h2468ACE0, 0, 0, 7, 4, 0, 32'h2468ACE0};
      tbl[14] = '{1, 23'h013000, 1, 32'hFEEDFACE, 4'h9, 1, 32'h0, 0, 0, 5, 1, 0, 32'h0};

      reset = 1'b1; psel_a = 0; psel_b = 0; penable = 0; pwrite = 0;
      paddr = '0; pwdata = '0; pstrb = '0;
      tgt_ack_a = '0; tgt_err_a = '0; tgt_rdata_a = '0;
      tgt_ack_b = '0; tgt_err_b = '0; tgt_rdata_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs_a", 64'({pready_a, pslverr_a, prdata_a, |tgt_req_a, tgt_we_a, tgt_addr_a, timeout_cnt_a}), 0);
      chk("reset_outputs_b", 64'({pready_b, pslverr_b, prdata_b, |tgt_req_b, tgt_we_b, tgt_addr_b, timeout_cnt_b}), 0);
      chk("reset_wdata_a", {tgt_wdata_a, tgt_wstrb_a}, 0);
      @(negedge clk); reset = 1'b0;

      for (int i = 0; i < 15; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
      chk("timeout_cnt_a", timeout_cnt_a, cnt_a);
      chk("timeout_cnt_b", timeout_cnt_b, cnt_b);

      // Late ack while idle must not produce a response.
      @(posedge clk); #1;
      tgt_ack_b = '1; tgt_ack_a = '1;
      repeat (2) begin
         @(posedge clk); #1;
         chk("idle_ack_pready_b", pready_b, 0);
         chk("idle_ack_req_b", tgt_req_b, 0);
      end
      tgt_ack_b = '0; tgt_ack_a = '0;
      chk("idle_ack_timeout_cnt_b", timeout_cnt_b, cnt_b);

      // psel falling during the wait aborts without a response.
      @(posedge clk); #1;
      paddr = 23'h001000; pwrite = 0; psel_a = 1; penable = 0;
      @(posedge clk); #1;
      penable = 1;
      chk("abort_req_before", tgt_req_a, NTA'(2));
      psel_a = 0; penable = 0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("abort_req_after", tgt_req_a, 0);
         chk("abort_no_pready", pready_a, 0);
      end
      run_vec(tbl[0], "after_abort");

      // Reset during wait drops the request immediately.
      @(posedge clk); #1;
      paddr = 23'h002004; pwrite = 0; psel_a = 1; penable = 0;
      @(posedge clk); #1;
      penable = 1;
      chk("rst_req_before", tgt_req_a, NTA'(4));
      reset = 1'b1;
      #1;
      chk("rst_req_dropped", tgt_req_a, 0);
      chk("rst_no_pready", pready_a, 0);
      chk("rst_timeout_cnt", timeout_cnt_a, 0);
      cnt_a = 0; cnt_b = 0;
      psel_a = 0; penable = 0;
      @(negedge clk); reset = 1'b0;
      run_vec(tbl[1], "after_reset");

      for (int i = 0; i < 40; i++) begin
         v.b       = ($urandom_range(0, 3) == 0);
         v.addr    = '0;
         v.addr[18:16] = 3'($urandom_range(0, 7));
         v.addr[15:12] = 4'($urandom_range(0, 5));
         v.addr[11:0]  = 12'($urandom_range(0, 1023) * 4);
         t = $urandom_range(0, 9);
         if (t == 0) v.addr[1:0] = 2'($urandom_range(1, 3));
         if (t == 1) v.addr[20] = 1'b1;
         v.wr      = $urandom_range(0, 1) == 1;
         v.wd      = $urandom;
         v.st      = 4'($urandom_range(0, 15));
         v.ack_cyc = $urandom_range(0, (v.b ? TB : TA) + 1);
         v.rd      = $urandom;
         v.aerr    = ($urandom_range(0, 4) == 0);
         v         = fill_expect(v);
         run_vec(v, $sformatf("rnd%0d", i));
      end
      chk("final_timeout_cnt_a", timeout_cnt_a, cnt_a);
      chk("final_timeout_cnt_b", timeout_cnt_b, cnt_b);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
